// File: rtl/de0_reset_seq.sv
// de0_reset_seq: turns the board PLL lock flag into a clean system reset and
// the 6502 core clock-enable. The lock flag is synchronised, reset is held
// for a settle time after lock, short lock-loss glitches during RUN are
// filtered out, and once running the system clock is divided into cpu_ce.
// The FSM state is exported on 'state' for debug and checker binding.
module de0_reset_seq #(
   parameter logic [15:0] HOLD_CYCLES = 16'd1024, // settle cycles in HOLD (>=1)
   parameter int          LOSS_FILT   = 4         // unlocked RUN cycles that force re-reset (>=1)
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       locked,
   input  logic       turbo,
   input  logic [7:0] div,
   output logic       sys_rst,
   output logic       ready,
   output logic       cpu_ce,
   output logic [1:0] state
);

   localparam int LW = $clog2(LOSS_FILT) + 1;
   localparam logic [LW-1:0] LCNT_MAX = LW'(LOSS_FILT - 1);
   localparam logic [15:0]   HCNT_MAX = HOLD_CYCLES - 16'd1;

   typedef enum logic [1:0] {
      S_WAIT = 2'b00,
      S_HOLD = 2'b01,
      S_RUN  = 2'b10
   } state_t;

   state_t          state_q;
   logic            sync1_q;
   logic            lock_s_q;
   logic [15:0]     hcnt_q;
   logic [LW-1:0]   lcnt_q;
   logic [7:0]      dcnt_q;
   logic [7:0]      dcnt_d;
   logic [7:0]      eff_m1;
   logic            run;

   // Two-flop synchroniser for the asynchronous PLL lock flag.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= locked;
         lock_s_q <= sync1_q;
      end
   end

   // Divider terminal value: div==0 behaves like div==1. Comparing with >=
   // means a div lowered below the running count fires at once instead of
   // letting the count wrap through 255.
   always_comb begin
      eff_m1 = (div == 8'd0) ? 8'd0 : (div - 8'd1);
      run    = (state_q == S_RUN);
      cpu_ce = run & (turbo | (dcnt_q >= eff_m1));
      dcnt_d = cpu_ce ? 8'd0 : (dcnt_q + 8'd1);
   end

   // Reset sequencing FSM together with its hold, loss-filter and divider counters.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q <= S_WAIT;
         hcnt_q  <= 16'd0;
         lcnt_q  <= '0;
         dcnt_q  <= 8'd0;
      end else begin
         case (state_q)
            S_WAIT: begin
               hcnt_q <= 16'd0;
               lcnt_q <= '0;
               dcnt_q <= 8'd0;
               if (lock_s_q) begin
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: begin
               lcnt_q <= '0;
               dcnt_q <= 8'd0;
               if (!lock_s_q) begin
                  // Any lock loss while settling restarts the whole sequence.
                  state_q <= S_WAIT;
                  hcnt_q  <= 16'd0;
               end else if (hcnt_q == HCNT_MAX) begin
                  state_q <= S_RUN;
                  hcnt_q  <= 16'd0;
               end else begin
                  hcnt_q <= hcnt_q + 16'd1;
               end
            end
            S_RUN: begin
               hcnt_q <= 16'd0;
               if (!lock_s_q && (lcnt_q == LCNT_MAX)) begin
                  state_q <= S_WAIT;
                  lcnt_q  <= '0;
                  dcnt_q  <= 8'd0;
               end else begin
                  lcnt_q <= lock_s_q ? '0 : (lcnt_q + 1'b1);
                  dcnt_q <= dcnt_d;
               end
            end
            default: begin
               // Unused encoding 2'b11 recovers to WAIT.
               state_q <= S_WAIT;
               hcnt_q  <= 16'd0;
               lcnt_q  <= '0;
               dcnt_q  <= 8'd0;
            end
         endcase
      end
   end

   assign sys_rst = (state_q != S_RUN);
   assign ready   = ~sys_rst;
   assign state   = state_q;

endmodule

// File: tb/tb_de0_reset_seq.sv
// Bench for de0_reset_seq with HOLD_CYCLES=16, LOSS_FILT=4.
// Inputs change and outputs are sampled on the falling clock edge; the DUT
// acts on the rising edge. Expected cpu_ce pulse positions are queued as
// cycle indices before each window and popped as the pulses appear.
module tb_de0_reset_seq;

   logic        clock;
   logic        rst;
   logic        locked;
   logic        turbo;
   logic [7:0]  div;
   logic        sys_rst;
   logic        ready;
   logic        cpu_ce;
   logic [1:0]  state;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [15:0] exp_q[$];
   logic        exp_ce;

   de0_reset_seq #(
      .HOLD_CYCLES(16'd16),
      .LOSS_FILT  (4)
   ) dut (
      .clock  (clock),
      .rst    (rst),
      .locked (locked),
      .turbo  (turbo),
      .div    (div),
      .sys_rst(sys_rst),
      .ready  (ready),
      .cpu_ce (cpu_ce),
      .state  (state)
   );

   // clock / watchdog
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded, got no finish, required finish");
      $fatal(1);
   end

   task automatic test_reset();
      rst = 1'b1; locked = 1'b0; turbo = 1'b0; div = 8'd25;
      repeat (3) @(negedge clock);
      total_cnt++; if (sys_rst !== 1'b1) $display("FAIL rst_sys_rst got %b want 1", sys_rst); else pass_cnt++;
      total_cnt++; if (ready !== 1'b0) $display("FAIL rst_ready got %b want 0", ready); else pass_cnt++;
      total_cnt++; if (cpu_ce !== 1'b0) $display("FAIL rst_cpu_ce got %b want 0", cpu_ce); else pass_cnt++;
      total_cnt++; if (state !== 2'b00) $display("FAIL rst_state got %b want 00", state); else pass_cnt++;
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         total_cnt++;
         if ({sys_rst, cpu_ce, state} !== 4'b1000)
            $display("FAIL unlocked_idle cyc %0d got sys_rst=%b ce=%b st=%b want 1 0 00", i, sys_rst, cpu_ce, state);
         else pass_cnt++;
      end
   endtask

   task automatic test_lock_release();
      locked = 1'b1;                     // sampled at the next rising edge E1
      @(negedge clock); @(negedge clock);  // after E2
      total_cnt++; if (state !== 2'b00) $display("FAIL sync_e2_state got %b want 00", state); else pass_cnt++;
      @(negedge clock);                  // after E3
      total_cnt++; if (state !== 2'b01) $display("FAIL hold_e3_state got %b want 01", state); else pass_cnt++;
      repeat (15) @(negedge clock);      // after E18
      total_cnt++; if (sys_rst !== 1'b1) $display("FAIL hold_e18_sys_rst got %b want 1", sys_rst); else pass_cnt++;
      @(negedge clock);                  // after E19
      total_cnt++; if (state !== 2'b10) $display("FAIL run_e19_state got %b want 10", state); else pass_cnt++;
      total_cnt++; if (sys_rst !== 1'b0) $display("FAIL run_e19_sys_rst got %b want 0", sys_rst); else pass_cnt++;
      total_cnt++; if (ready !== 1'b1) $display("FAIL run_e19_ready got %b want 1", ready); else pass_cnt++;
   endtask

   task automatic test_divider();
      // RUN cycle 0 now; div=25 gives pulses at 24, 49, 74
      exp_q.delete(); exp_q.push_back(16'd24); exp_q.push_back(16'd49); exp_q.push_back(16'd74);
      for (int c = 0; c < 80; c++) begin
         #1;
         exp_ce = (exp_q.size() > 0) && (exp_q[0] == c);
         total_cnt++;
         if (cpu_ce !== exp_ce) $display("FAIL div25_ce cyc %0d got %b want %b", c, cpu_ce, exp_ce);
         else pass_cnt++;
         if (exp_ce) void'(exp_q.pop_front());
         @(negedge clock);
      end
      div = 8'd0;
      for (int c = 0; c < 5; c++) begin
         #1; total_cnt++;
         if (cpu_ce !== 1'b1) $display("FAIL div0_ce cyc %0d got %b want 1", c, cpu_ce); else pass_cnt++;
         @(negedge clock);
      end
      div = 8'd1;
      for (int c = 0; c < 5; c++) begin
         #1; total_cnt++;
         if (cpu_ce !== 1'b1) $display("FAIL div1_ce cyc %0d got %b want 1", c, cpu_ce); else pass_cnt++;
         @(negedge clock);
      end
   endtask

   task automatic test_turbo();
      div = 8'd25; turbo = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1; total_cnt++;
         if (cpu_ce !== 1'b1) $display("FAIL turbo_ce cyc %0d got %b want 1", c, cpu_ce); else pass_cnt++;
         @(negedge clock);
      end
      // Leaving turbo restarts the count from 0: first pulse 24 cycles later.
      turbo = 1'b0;
      exp_q.delete(); exp_q.push_back(16'd24);
      for (int c = 0; c < 30; c++) begin
         #1;
         exp_ce = (exp_q.size() > 0) && (exp_q[0] == c);
         total_cnt++;
         if (cpu_ce !== exp_ce) $display("FAIL turbo_off_ce cyc %0d got %b want %b", c, cpu_ce, exp_ce);
         else pass_cnt++;
         if (exp_ce) void'(exp_q.pop_front());
         @(negedge clock);
      end
   endtask

   task automatic test_loss_filter();
      // 3-cycle glitch: ignored
      locked = 1'b0;
      for (int i = 0; i < 11; i++) begin
         @(negedge clock);
         if (i == 2) locked = 1'b1;
         total_cnt++;
         if ({sys_rst, state} !== 3'b010)
            $display("FAIL glitch3 cyc %0d got sys_rst=%b st=%b want 0 10", i, sys_rst, state);
         else pass_cnt++;
      end
      // 4-cycle loss: re-reset, then release 18 cycles after relock
      locked = 1'b0;
      for (int n = 1; n <= 23; n++) begin
         @(negedge clock);
         if (n == 4) locked = 1'b1;
         if (n == 5) begin
            total_cnt++; if (sys_rst !== 1'b0) $display("FAIL loss4_n5_sys_rst got %b want 0", sys_rst); else pass_cnt++;
         end
         if (n == 6) begin
            total_cnt++; if (sys_rst !== 1'b1) $display("FAIL loss4_n6_sys_rst got %b want 1", sys_rst); else pass_cnt++;
            total_cnt++; if (state !== 2'b00) $display("FAIL loss4_n6_state got %b want 00", state); else pass_cnt++;
         end
         if (n == 7) begin
            total_cnt++; if (state !== 2'b01) $display("FAIL loss4_n7_state got %b want 01", state); else pass_cnt++;
         end
         if (n == 22) begin
            total_cnt++; if (sys_rst !== 1'b1) $display("FAIL relock_n22_sys_rst got %b want 1", sys_rst); else pass_cnt++;
         end
         if (n == 23) begin
            total_cnt++; if (sys_rst !== 1'b0) $display("FAIL relock_n23_sys_rst got %b want 0", sys_rst); else pass_cnt++;
         end
      end
   endtask

   task automatic test_hold_glitch();
      rst = 1'b1; div = 8'd200;
      #1; total_cnt++;
      if ({sys_rst, state} !== 3'b100) $display("FAIL hg_rst got sys_rst=%b st=%b want 1 00", sys_rst, state); else pass_cnt++;
      @(negedge clock);
      rst = 1'b0;                        // locked already high
      for (int k = 1; k <= 33; k++) begin
         @(negedge clock);
         if (k == 13 || k == 15 || k == 17 || k == 32) begin
            total_cnt++; if (state !== 2'b01) $display("FAIL hg_state k%0d got %b want 01", k, state); else pass_cnt++;
         end
         if (k == 16) begin
            total_cnt++; if (state !== 2'b00) $display("FAIL hg_state k16 got %b want 00", state); else pass_cnt++;
         end
         if (k == 33) begin
            total_cnt++; if (state !== 2'b10) $display("FAIL hg_state k33 got %b want 10", state); else pass_cnt++;
         end
         if (k == 13) locked = 1'b0;     // hcnt is 10 here
         if (k == 14) locked = 1'b1;
      end
   endtask

   task automatic test_div_change();
      // RUN cycle 0, div=200: no pulse through cycle 99
      for (int c = 0; c < 100; c++) begin
         #1; total_cnt++;
         if (cpu_ce !== 1'b0) $display("FAIL div200_ce cyc %0d got %b want 0", c, cpu_ce); else pass_cnt++;
         @(negedge clock);
      end
      // count is 100; lowering div to 50 fires in the first cycle it is seen
      div = 8'd50;
      exp_q.delete(); exp_q.push_back(16'd0); exp_q.push_back(16'd50); exp_q.push_back(16'd100);
      for (int c = 0; c < 110; c++) begin
         #1;
         exp_ce = (exp_q.size() > 0) && (exp_q[0] == c);
         total_cnt++;
         if (cpu_ce !== exp_ce) $display("FAIL div50_ce cyc %0d got %b want %b", c, cpu_ce, exp_ce);
         else pass_cnt++;
         if (exp_ce) void'(exp_q.pop_front());
         @(negedge clock);
      end
   endtask

   task automatic test_rst_mid_run();
      div = 8'd1;                        // cpu_ce high until reset takes effect
      rst = 1'b1;
      #1;
      total_cnt++; if (sys_rst !== 1'b1) $display("FAIL midrst_sys_rst got %b want 1", sys_rst); else pass_cnt++;
      total_cnt++; if (ready !== 1'b0) $display("FAIL midrst_ready got %b want 0", ready); else pass_cnt++;
      total_cnt++; if (cpu_ce !== 1'b0) $display("FAIL midrst_cpu_ce got %b want 0", cpu_ce); else pass_cnt++;
      total_cnt++; if (state !== 2'b00) $display("FAIL midrst_state got %b want 00", state); else pass_cnt++;
      @(negedge clock); @(negedge clock);
      total_cnt++; if (state !== 2'b00) $display("FAIL midrst_held_state got %b want 00", state); else pass_cnt++;
      rst = 1'b0;
      for (int n = 1; n <= 19; n++) begin
         @(negedge clock);
         if (n == 2) begin
            total_cnt++; if (state !== 2'b00) $display("FAIL rerun_n2_state got %b want 00", state); else pass_cnt++;
         end
         if (n == 3 || n == 18) begin
            total_cnt++; if (state !== 2'b01) $display("FAIL rerun_n%0d_state got %b want 01", n, state); else pass_cnt++;
         end
         if (n == 19) begin
            total_cnt++; if (state !== 2'b10) $display("FAIL rerun_n19_state got %b want 10", state); else pass_cnt++;
            total_cnt++; if (cpu_ce !== 1'b1) $display("FAIL rerun_n19_ce got %b want 1", cpu_ce); else pass_cnt++;
         end
      end
   endtask

   // sequence and final report
   initial begin
      test_reset();
      test_lock_release();
      test_divider();
      test_turbo();
      test_loss_filter();
      test_hold_glitch();
      test_div_change();
      test_rst_mid_run();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
